// File: rtl/sw_event_pkg.sv
// rtl/sw_event_pkg.sv - register map, bit positions and event word layout for sw_event_core
package sw_event_pkg;

    localparam logic [4:0] REG_DATA   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd1;
    localparam logic [4:0] REG_DB     = 5'd2;
    localparam logic [4:0] REG_POP    = 5'd3;
    localparam logic [4:0] REG_CTRL   = 5'd4;
    localparam logic [4:0] REG_TS     = 5'd5;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_FLUSH   = 2;

    typedef struct packed {
        logic [15:0] ts;
        logic        level;
        logic [10:0] rsvd;
        logic [3:0]  idx;
    } event_t;

endpackage

// File: rtl/sw_debounce_cell.sv
// rtl/sw_debounce_cell.sv - 2-FF synchroniser and stability counter for one switch bit
module sw_debounce_cell #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw,
    output logic o_db,
    output logic o_edge
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_db;
    logic             r_edge;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_edge <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
            r_edge <= 1'b0;
            // Any return to the debounced level restarts the stability window.
            if (r_sync != r_db) begin
                if (r_cnt == CNT_LAST) begin
                    r_db   <= r_sync;
                    r_cnt  <= '0;
                    r_edge <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_db   = r_db;
    assign o_edge = r_edge;

endmodule

// File: rtl/sw_event_core.sv
// rtl/sw_event_core.sv - debounced switch edge events, timestamped and queued for MMIO readout
module sw_event_core
    import sw_event_pkg::*;
#(
    parameter int SW_WIDTH    = 16,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int TICK_CYCLES = 100_000,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                read,
    input  logic                write,
    input  logic [4:0]          addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data,
    input  logic [SW_WIDTH-1:0] sw
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    logic [SW_WIDTH-1:0] w_db;
    logic [SW_WIDTH-1:0] w_edge;

    for (genvar g = 0; g < SW_WIDTH; g++) begin : g_cell
        sw_debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
            .clk    (clk),
            .reset  (reset),
            .i_sw   (sw[g]),
            .o_db   (w_db[g]),
            .o_edge (w_edge[g])
        );
    end

    logic [PRE_W-1:0]    r_pre;
    logic [15:0]         r_ts;
    logic                r_en;
    logic                r_ovf;
    logic [SW_WIDTH-1:0] r_pend;
    event_t              r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_ctrl_wr;
    logic                w_pop_req;
    logic                w_flush;
    logic                w_clr_ovf;
    logic                w_pend_clr;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_do_push;
    logic                w_do_pop;
    logic                w_drop;
    logic [SW_WIDTH-1:0] w_grant;
    logic [3:0]          w_svc_idx;
    event_t              w_evt;
    logic [31:0]         w_rd;
    logic                w_unused;

    assign w_ctrl_wr  = cs && write && (addr == REG_CTRL);
    assign w_pop_req  = cs && write && (addr == REG_POP);
    assign w_flush    = w_ctrl_wr && wr_data[CTRL_FLUSH];
    assign w_clr_ovf  = w_ctrl_wr && wr_data[CTRL_CLR_OVF];
    assign w_pend_clr = w_flush || (w_ctrl_wr && !wr_data[CTRL_EN]);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));

    // Lowest set pending bit wins; isolate it as a one-hot grant.
    assign w_grant = r_pend & (~r_pend + SW_WIDTH'(1));

    always_comb begin
        w_svc_idx = 4'd0;
        for (int i = SW_WIDTH - 1; i >= 0; i--) begin
            if (r_pend[i]) w_svc_idx = 4'(i);
        end
    end

    always_comb begin
        w_evt       = '0;
        w_evt.ts    = r_ts;
        w_evt.level = |(w_db & w_grant);
        w_evt.idx   = w_svc_idx;
    end

    assign w_push    = (|r_pend) && !w_flush;
    assign w_do_pop  = w_pop_req && !w_empty && !w_flush;
    assign w_do_push = w_push && (!w_full || w_do_pop);
    assign w_drop    = w_push && w_full && !w_do_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_ts  <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_ts  <= r_ts + 16'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en   <= 1'b0;
            r_ovf  <= 1'b0;
            r_pend <= '0;
        end else begin
            if (w_ctrl_wr) r_en <= wr_data[CTRL_EN];
            r_ovf <= (r_ovf && !w_clr_ovf) || w_drop;
            if (w_pend_clr) r_pend <= '0;
            else            r_pend <= (r_pend & ~w_grant) | (r_en ? w_edge : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= w_evt;
    end

    always_comb begin
        w_rd = '0;
        if (cs) begin
            case (addr)
                REG_DATA:   w_rd = w_empty ? 32'd0 : r_mem[r_rd_ptr];
                REG_STATUS: begin
                    w_rd[ST_EMPTY]        = w_empty;
                    w_rd[ST_FULL]         = w_full;
                    w_rd[ST_OVF]          = r_ovf;
                    w_rd[ST_CNT_LSB +: 8] = 8'(r_count);
                end
                REG_DB:     w_rd[SW_WIDTH-1:0] = w_db;
                REG_CTRL:   w_rd[CTRL_EN] = r_en;
                REG_TS:     w_rd[15:0] = r_ts;
                default:    w_rd = '0;
            endcase
        end
    end

    assign rd_data  = w_rd;
    assign w_unused = &{1'b0, read, wr_data[31:3]};

endmodule

// File: tb/tb_sw_event_core.sv
// tb/tb_sw_event_core.sv - scoreboard bench for sw_event_core register reads
module tb_sw_event_core;
    import sw_event_pkg::*;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [15:0] sw;

    sw_event_core #(
        .SW_WIDTH    (16),
        .DB_CYCLES   (8),
        .TICK_CYCLES (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .sw      (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release; the timestamp is this divided by TICK_CYCLES.
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    logic [31:0] exp_q [$];
    string       name_q [$];
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (cs && read) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: addr %0d got %h with no expectation", addr, rd_data);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, rd_data, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        tick(1);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
        tick(1);
        cs = 1'b0; write = 1'b0;
    endtask

    function automatic logic [31:0] ev(input int ts, input logic level, input logic [3:0] idx);
        logic [15:0] t;
        t = 16'(ts);
        return {t, level, 11'd0, idx};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m;
        int m6;
        int g;
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0; sw = '0;
        tick(2);
        reset = 1'b0;

        rd(REG_TS,     32'h0, "rst_ts");
        rd(REG_STATUS, 32'h1, "rst_status");
        rd(REG_DATA,   32'h0, "rst_data");
        rd(REG_DB,     32'h0, "rst_db");
        rd(REG_CTRL,   32'h0, "rst_ctrl");
        wr(REG_CTRL,   32'h1);
        rd(REG_CTRL,   32'h1, "ctrl_enable");

        // Rise of sw[5] lands its push in the cycle where ts = 7.
        g = 0;
        while (cyc < 17 && g < 100) begin tick(1); g++; end
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL align_cycle: got %0d expected 17", cyc);
        end
        sw[5] = 1'b1;
        tick(14);
        rd(REG_DATA,   32'h0007_8005, "fmt_rise");
        rd(REG_STATUS, 32'h0000_0100, "fmt_count1");
        m = cyc;
        sw[5] = 1'b0;
        tick(14);
        wr(REG_POP, 32'h0);
        rd(REG_DATA,   ev((m + 11) / 4, 1'b0, 4'd5), "fmt_fall");
        wr(REG_POP, 32'h0);
        rd(REG_STATUS, 32'h1, "fmt_empty");

        m = cyc;
        sw[3] = 1'b1;
        tick(9);
        rd(REG_DB, 32'h0000, "db_before");
        rd(REG_DB, 32'h0008, "db_after");
        tick(5);
        sw[3] = 1'b0;
        tick(5);
        sw[3] = 1'b1;
        tick(20);
        rd(REG_DB,     32'h0008, "db_glitch");
        rd(REG_STATUS, 32'h0100, "db_one_event");
        rd(REG_DATA,   ev((m + 11) / 4, 1'b1, 4'd3), "db_event");
        wr(REG_CTRL, 32'h5);
        rd(REG_STATUS, 32'h1, "flush_db");

        m = cyc;
        sw[0] = 1'b1; sw[2] = 1'b1;
        tick(12);
        rd(REG_STATUS, 32'h0100, "sim_first_push");
        rd(REG_STATUS, 32'h0200, "sim_second_push");
        rd(REG_DATA, ev((m + 11) / 4, 1'b1, 4'd0), "sim_idx0");
        wr(REG_POP, 32'h0);
        rd(REG_DATA, ev((m + 12) / 4, 1'b1, 4'd2), "sim_idx2");
        wr(REG_POP, 32'h0);
        rd(REG_STATUS, 32'h1, "sim_empty");

        m6 = cyc;
        sw[4] = 1'b1; sw[9:6] = 4'hF;
        tick(20);
        rd(REG_STATUS, 32'h0406, "ovf_status");
        rd(REG_DATA, ev((m6 + 11) / 4, 1'b1, 4'd4), "ovf_head");
        wr(REG_CTRL, 32'h3);
        rd(REG_STATUS, 32'h0402, "ovf_cleared");
        wr(REG_POP, 32'h0);
        rd(REG_STATUS, 32'h0300, "ovf_pop");

        // sw[10] refills to full; sw[11]'s push coincides with the pop write.
        sw[10] = 1'b1;
        tick(1);
        sw[11] = 1'b1;
        tick(11);
        wr(REG_POP, 32'h0);
        rd(REG_STATUS, 32'h0402, "full_pushpop");
        rd(REG_DATA, ev((m6 + 13) / 4, 1'b1, 4'd7), "full_head");
        wr(REG_CTRL, 32'h5);
        rd(REG_STATUS, 32'h1, "flush_empty");
        wr(REG_POP, 32'h0);
        rd(REG_STATUS, 32'h1, "pop_empty");
        rd(REG_DATA,   32'h0, "empty_data");

        sw[15:12] = 4'hF;
        tick(12);
        rd(REG_STATUS, 32'h0100, "pre_reset_count");
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rd(REG_TS,     32'h0, "mid_rst_ts");
        rd(REG_STATUS, 32'h1, "mid_rst_status");
        rd(REG_DATA,   32'h0, "mid_rst_data");
        rd(REG_DB,     32'h0, "mid_rst_db");
        rd(REG_CTRL,   32'h0, "mid_rst_ctrl");
        tick(20);
        rd(REG_STATUS, 32'h1, "mid_rst_no_events");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
